// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Drives a combinational ALU through every command code for one latched
//   operand pair. Each code is held on the ALU for SETTLE cycles, d_out is
//   sampled, and {cmd, result} is offered on a valid/ready result stream.
//
// Optional feature macro: ALU_SEQ_CMD_MASK_EN
//   Adds cmd_mask[NUM_CMDS-1:0], latched on start; codes with a zero mask
//   bit are skipped in zero cycles. An all-zero mask goes straight to DONE.
//
// Ports:
//   clk, rst_n             clock (rising), async active-low reset
//   start, op_a, op_b      sweep request and operands (accepted in IDLE)
//   cmd_mask               per-code enable (only with ALU_SEQ_CMD_MASK_EN)
//   busy, done             sweep in progress / one-cycle completion pulse
//   a_out, b_out, cmd_out, oe_out   to ALU a_in, b_in, command_in, oe
//   alu_d_in               from ALU d_out
//   res_valid, res_ready, res_cmd, res_data   result stream
module alu_cmd_sequencer #(
  parameter int DATA_W   = 8,
  parameter int CMD_W    = 4,
  parameter int NUM_CMDS = 16,
  parameter int SETTLE   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
`ifdef ALU_SEQ_CMD_MASK_EN
  input  logic [NUM_CMDS-1:0]   cmd_mask,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     a_out,
  output logic [DATA_W-1:0]     b_out,
  output logic [CMD_W-1:0]      cmd_out,
  output logic                  oe_out,
  input  logic [2*DATA_W-1:0]   alu_d_in,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CMD_W-1:0]      res_cmd,
  output logic [2*DATA_W-1:0]   res_data
);

  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_DONE} state_t;

  state_t                state;
  logic [CMD_W-1:0]      idx;
  logic [CNT_W-1:0]      cnt;
  logic [NUM_CMDS-1:0]   mask_q;
  logic [NUM_CMDS-1:0]   start_mask;
  logic [CMD_W:0]        first_hit;
  logic [CMD_W:0]        next_hit;

`ifdef ALU_SEQ_CMD_MASK_EN
  assign start_mask = cmd_mask;
`else
  assign start_mask = '1;
`endif

  // Lowest enabled index >= from; MSB of the result flags "found".
  // Scanning high-to-low lets the last hit win, which is the lowest one.
  function automatic logic [CMD_W:0] find_from(input logic [NUM_CMDS-1:0] m,
                                               input int from);
    logic [CMD_W:0] r;
    r = '0;
    for (int i = NUM_CMDS - 1; i >= 0; i--)
      if (m[i] && i >= from) r = {1'b1, CMD_W'(i)};
    return r;
  endfunction

  assign first_hit = find_from(start_mask, 0);
  assign next_hit  = find_from(mask_q, int'(idx) + 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      oe_out    <= 1'b0;
      res_valid <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      cmd_out   <= '0;
      res_cmd   <= '0;
      res_data  <= '0;
      idx       <= '0;
      cnt       <= '0;
      mask_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_out  <= op_a;
            b_out  <= op_b;
            mask_q <= start_mask;
            busy   <= 1'b1;
            if (first_hit[CMD_W]) begin
              idx     <= first_hit[CMD_W-1:0];
              cmd_out <= first_hit[CMD_W-1:0];
              oe_out  <= 1'b1;
              cnt     <= CNT_W'(SETTLE);
              state   <= S_DRIVE;
            end else begin
              // nothing enabled: complete immediately, no results
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DRIVE: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            res_data  <= alu_d_in;
            res_cmd   <= idx;
            res_valid <= 1'b1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // res_valid is always high here, so ready alone is the handshake
          if (res_ready) begin
            res_valid <= 1'b0;
            if (next_hit[CMD_W]) begin
              idx     <= next_hit[CMD_W-1:0];
              cmd_out <= next_hit[CMD_W-1:0];
              cnt     <= CNT_W'(SETTLE);
              state   <= S_DRIVE;
            end else begin
              oe_out <= 1'b0;
              done   <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer. Two instances: SETTLE=1 (dut) and
// SETTLE=3 (dut3), each fed by an ALU stub d_out = a*b + cmd.
module tb_alu_cmd_sequencer;
  logic        clk;
  logic        rst_n;
  logic        start, ready;
  logic [7:0]  op_a, op_b;
  logic        busy, done, oe, res_valid;
  logic [7:0]  a_out, b_out;
  logic [3:0]  cmd_out, res_cmd;
  logic [15:0] alu_d, res_data;

  logic        start3, ready3;
  logic [7:0]  op_a3, op_b3;
  logic        busy3, done3, oe3, res_valid3;
  logic [7:0]  a_out3, b_out3;
  logic [3:0]  cmd_out3, res_cmd3;
  logic [15:0] alu_d3, res_data3;
`ifdef ALU_SEQ_CMD_MASK_EN
  logic [15:0] cmd_mask, cmd_mask3;
`endif

  int total, bad;

  assign alu_d  = oe  ? (16'(a_out)  * 16'(b_out)  + 16'(cmd_out))  : 16'h0;
  assign alu_d3 = oe3 ? (16'(a_out3) * 16'(b_out3) + 16'(cmd_out3)) : 16'h0;

  alu_cmd_sequencer #(.DATA_W(8), .CMD_W(4), .NUM_CMDS(16), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
`ifdef ALU_SEQ_CMD_MASK_EN
    .cmd_mask(cmd_mask),
`endif
    .busy(busy), .done(done), .a_out(a_out), .b_out(b_out),
    .cmd_out(cmd_out), .oe_out(oe), .alu_d_in(alu_d),
    .res_valid(res_valid), .res_ready(ready), .res_cmd(res_cmd),
    .res_data(res_data)
  );

  alu_cmd_sequencer #(.DATA_W(8), .CMD_W(4), .NUM_CMDS(16), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .op_a(op_a3), .op_b(op_b3),
`ifdef ALU_SEQ_CMD_MASK_EN
    .cmd_mask(cmd_mask3),
`endif
    .busy(busy3), .done(done3), .a_out(a_out3), .b_out(b_out3),
    .cmd_out(cmd_out3), .oe_out(oe3), .alu_d_in(alu_d3),
    .res_valid(res_valid3), .res_ready(ready3), .res_cmd(res_cmd3),
    .res_data(res_data3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({busy, done, res_valid, oe, a_out, b_out, cmd_out, res_cmd, res_data} !== 44'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {busy, done, res_valid, oe, a_out, b_out, cmd_out, res_cmd, res_data});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, res_valid, oe} !== 4'b0) begin
      bad++;
      $display("FAIL reset_idle got=%b want=0000", {busy, done, res_valid, oe});
    end
  endtask

  // Full sweep with ready held high, plus a start pulse (op_a=7) mid-sweep
  // which must be ignored.
  task automatic test_sweep;
    int k, last, dones;
    k = 0; last = -10; dones = 0;
    op_a = 8'd50; op_b = 8'd10; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({busy, oe, cmd_out, a_out, b_out} !== {1'b1, 1'b1, 4'd0, 8'd50, 8'd10}) begin
      bad++;
      $display("FAIL sweep_accept got busy=%b oe=%b cmd=%0d a=%0d b=%0d want 1 1 0 50 10",
               busy, oe, cmd_out, a_out, b_out);
    end
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (res_valid) begin
        total++;
        if (res_cmd !== 4'(k) || res_data !== 16'(500 + k)) begin
          bad++;
          $display("FAIL sweep_data got cmd=%0d data=%0d want cmd=%0d data=%0d",
                   res_cmd, res_data, k, 500 + k);
        end
        if (k > 0) begin
          total++;
          if (c - last != 2) begin
            bad++;
            $display("FAIL sweep_rate got gap=%0d want 2", c - last);
          end
        end
        last = c; k++;
      end
      if (done) begin
        dones++;
        total++;
        if (c != last + 1) begin
          bad++;
          $display("FAIL sweep_done_timing got cycle=%0d want %0d", c, last + 1);
        end
      end
      start = (c == 6);
      if (c == 6) begin op_a = 8'd7; op_b = 8'd3; end
      if (dones > 0 && !busy) break;
    end
    total++;
    if (k != 16 || dones != 1) begin
      bad++;
      $display("FAIL sweep_count got results=%0d dones=%0d want 16 1", k, dones);
    end
    total++;
    if ({busy, oe, a_out, b_out, cmd_out} !== {1'b0, 1'b0, 8'd50, 8'd10, 4'd15}) begin
      bad++;
      $display("FAIL sweep_end got busy=%b oe=%b a=%0d b=%0d cmd=%0d want 0 0 50 10 15",
               busy, oe, a_out, b_out, cmd_out);
    end
  endtask

  task automatic test_backpressure;
    int k, dones;
    bit stalled;
    k = 0; dones = 0; stalled = 0;
    op_a = 8'd50; op_b = 8'd10; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (res_valid && !(stalled && res_cmd == 4'd3)) begin
        total++;
        if (res_cmd !== 4'(k) || res_data !== 16'(500 + k)) begin
          bad++;
          $display("FAIL bp_data got cmd=%0d data=%0d want cmd=%0d data=%0d",
                   res_cmd, res_data, k, 500 + k);
        end
        k++;
      end
      if (done) dones++;
      if (res_valid && res_cmd == 4'd3 && !stalled) begin
        stalled = 1;
        ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          total++;
          if (res_valid !== 1'b1 || res_cmd !== 4'd3 || res_data !== 16'd503 || cmd_out !== 4'd3) begin
            bad++;
            $display("FAIL bp_hold got v=%b cmd=%0d data=%0d cmd_out=%0d want 1 3 503 3",
                     res_valid, res_cmd, res_data, cmd_out);
          end
        end
        ready = 1'b1;
        @(negedge clk);  // handshake edge has passed; cmd 3 consumed
        total++;
        if (res_valid !== 1'b0 || cmd_out !== 4'd4) begin
          bad++;
          $display("FAIL bp_resume got v=%b cmd_out=%0d want 0 4", res_valid, cmd_out);
        end
      end
      if (dones > 0 && !busy) break;
    end
    total++;
    if (k != 16 || dones != 1 || !stalled) begin
      bad++;
      $display("FAIL bp_count got results=%0d dones=%0d stalled=%0d want 16 1 1", k, dones, stalled);
    end
  endtask

  // Start held during the DONE cycle (op 9/9) must be ignored; start in the
  // following cycle (op 7/3) is accepted.
  task automatic test_back_to_back;
    int k, dones;
    bit seen;
    seen = 0; k = 0; dones = 0;
    op_a = 8'd50; op_b = 8'd10; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL b2b_first_done got none want pulse");
    end
    op_a = 8'd9; op_b = 8'd9; start = 1'b1;
    @(negedge clk);
    op_a = 8'd7; op_b = 8'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++;
    if (res_valid !== 1'b1 || res_cmd !== 4'd0 || res_data !== 16'd21) begin
      bad++;
      $display("FAIL b2b_first_result got v=%b cmd=%0d data=%0d want 1 0 21",
               res_valid, res_cmd, res_data);
    end
    for (int c = 0; c < 60; c++) begin
      if (res_valid) begin
        total++;
        if (res_data !== 16'(21 + k)) begin
          bad++;
          $display("FAIL b2b_data got %0d want %0d", res_data, 21 + k);
        end
        k++;
      end
      if (done) dones++;
      if (dones > 0 && !busy) break;
      @(negedge clk);
    end
    total++;
    if (k != 16 || dones != 1) begin
      bad++;
      $display("FAIL b2b_count got results=%0d dones=%0d want 16 1", k, dones);
    end
  endtask

  task automatic test_async_reset;
    bit hit;
    hit = 0;
    op_a = 8'd50; op_b = 8'd10; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      if (busy && !res_valid && cmd_out == 4'd8) hit = 1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL arst_reach_cmd8 got none want DRIVE cmd 8");
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, res_valid, oe, a_out, b_out, cmd_out, res_cmd, res_data} !== 44'h0) begin
      bad++;
      $display("FAIL arst_outputs got=%h want=0",
               {busy, done, res_valid, oe, a_out, b_out, cmd_out, res_cmd, res_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, res_valid, oe} !== 3'b0) begin
      bad++;
      $display("FAIL arst_idle got=%b want=000", {busy, res_valid, oe});
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++;
    if (res_valid !== 1'b1 || res_cmd !== 4'd0 || res_data !== 16'd500) begin
      bad++;
      $display("FAIL arst_restart got v=%b cmd=%0d data=%0d want 1 0 500",
               res_valid, res_cmd, res_data);
    end
    for (int c = 0; c < 60 && busy; c++) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL arst_drain got busy=%b want 0", busy);
    end
  endtask

  task automatic test_settle3;
    int k, last, dones;
    k = 0; last = -10; dones = 0;
    op_a3 = 8'd4; op_b3 = 8'd5; ready3 = 1'b1; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      total++;
      if (res_valid3 !== 1'b0 || cmd_out3 !== 4'd0 || oe3 !== 1'b1) begin
        bad++;
        $display("FAIL s3_hold cycle=%0d got v=%b cmd=%0d oe=%b want 0 0 1",
                 c, res_valid3, cmd_out3, oe3);
      end
      @(negedge clk);
    end
    for (int c = 4; c < 120; c++) begin
      if (res_valid3) begin
        total++;
        if (res_cmd3 !== 4'(k) || res_data3 !== 16'(20 + k)) begin
          bad++;
          $display("FAIL s3_data got cmd=%0d data=%0d want cmd=%0d data=%0d",
                   res_cmd3, res_data3, k, 20 + k);
        end
        total++;
        if ((k == 0 && c != 4) || (k > 0 && c - last != 4)) begin
          bad++;
          $display("FAIL s3_timing got cycle=%0d prev=%0d want first 4 gap 4", c, last);
        end
        last = c; k++;
      end
      if (done3) dones++;
      if (dones > 0 && !busy3) break;
      @(negedge clk);
    end
    total++;
    if (k != 16 || dones != 1) begin
      bad++;
      $display("FAIL s3_count got results=%0d dones=%0d want 16 1", k, dones);
    end
  endtask

`ifdef ALU_SEQ_CMD_MASK_EN
  task automatic test_mask;
    int k, dones, vcount;
    int exp_cmd [3];
    exp_cmd = '{0, 2, 15};
    k = 0; dones = 0; vcount = 0;
    cmd_mask = 16'h8005;
    op_a = 8'd50; op_b = 8'd10; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (res_valid) begin
        total++;
        if (k > 2 || res_cmd !== 4'(exp_cmd[k > 2 ? 2 : k]) ||
            res_data !== 16'(500 + exp_cmd[k > 2 ? 2 : k])) begin
          bad++;
          $display("FAIL mask_data got cmd=%0d data=%0d idx=%0d", res_cmd, res_data, k);
        end
        k++;
      end
      if (done) dones++;
      if (dones > 0 && !busy) break;
    end
    total++;
    if (k != 3 || dones != 1) begin
      bad++;
      $display("FAIL mask_count got results=%0d dones=%0d want 3 1", k, dones);
    end
    cmd_mask = 16'h0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL mask_zero_done got %b want 1", done);
    end
    for (int c = 0; c < 6; c++) begin
      if (res_valid) vcount++;
      @(negedge clk);
    end
    total++;
    if (vcount != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mask_zero_quiet got valids=%0d busy=%b want 0 0", vcount, busy);
    end
    cmd_mask = 16'hFFFF;
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; ready = 1'b0; op_a = '0; op_b = '0;
    start3 = 1'b0; ready3 = 1'b0; op_a3 = '0; op_b3 = '0;
`ifdef ALU_SEQ_CMD_MASK_EN
    cmd_mask = 16'hFFFF; cmd_mask3 = 16'hFFFF;
`endif
    test_reset();
    test_sweep();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_settle3();
`ifdef ALU_SEQ_CMD_MASK_EN
    test_mask();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
